// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - ALU op codes, RV32I opcode/funct constants and operand-select encodings
// Shared by the instruction decoder and the decode-stage pipeline register.
package decode_stage_pkg;

   localparam int ALUOP_WIDTH = 4;

   localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SLL  = 4'd2;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SLT  = 4'd3;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SLTU = 4'd4;
   localparam logic [ALUOP_WIDTH-1:0] ALU_XOR  = 4'd5;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SRL  = 4'd6;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SRA  = 4'd7;
   localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = 4'd8;
   localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = 4'd9;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   localparam logic [1:0] A_SEL_RS1  = 2'd0;
   localparam logic [1:0] A_SEL_PC   = 2'd1;
   localparam logic [1:0] A_SEL_ZERO = 2'd2;
   localparam logic       B_SEL_RS2  = 1'b0;
   localparam logic       B_SEL_IMM  = 1'b1;

   // funct3 -> ALU op assuming the base (funct7=0) variant
   function automatic logic [ALUOP_WIDTH-1:0] base_op(input logic [2:0] f3);
      case (f3)
         F3_ADD_SUB: base_op = ALU_ADD;
         F3_SLL:     base_op = ALU_SLL;
         F3_SLT:     base_op = ALU_SLT;
         F3_SLTU:    base_op = ALU_SLTU;
         F3_XOR:     base_op = ALU_XOR;
         F3_SR:      base_op = ALU_SRL;
         F3_OR:      base_op = ALU_OR;
         default:    base_op = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_instr_dec.sv
// rtl/decode_stage_instr_dec.sv - combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC
// Illegal encodings collapse to ADD, zero selects and zero immediate.
module instr_dec
   import decode_stage_pkg::*;
(
   input  logic [31:0]            instr,
   output logic [ALUOP_WIDTH-1:0] alu_op,
   output logic [1:0]             a_sel,
   output logic                   b_sel,
   output logic [31:0]            imm,
   output logic [4:0]             rs1,
   output logic [4:0]             rs2,
   output logic [4:0]             rd,
   output logic                   rd_we,
   output logic                   illegal
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign rd     = instr[11:7];

   always_comb begin
      alu_op  = ALU_ADD;
      a_sel   = A_SEL_RS1;
      b_sel   = B_SEL_RS2;
      imm     = '0;
      illegal = 1'b0;
      if (instr[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (opcode)
            OPC_LUI: begin
               a_sel = A_SEL_ZERO;
               b_sel = B_SEL_IMM;
               imm   = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
               a_sel = A_SEL_PC;
               b_sel = B_SEL_IMM;
               imm   = {instr[31:12], 12'b0};
            end
            OPC_OP_IMM: begin
               b_sel  = B_SEL_IMM;
               alu_op = base_op(f3);
               imm    = {{20{instr[31]}}, instr[31:20]};
               // shift immediates carry only the shamt; the upper bits are funct7
               if (f3 == F3_SLL) begin
                  imm = {27'b0, instr[24:20]};
                  if (f7 != F7_BASE) illegal = 1'b1;
               end else if (f3 == F3_SR) begin
                  imm = {27'b0, instr[24:20]};
                  if (f7 == F7_ALT) alu_op = ALU_SRA;
                  else if (f7 != F7_BASE) illegal = 1'b1;
               end
            end
            OPC_OP: begin
               alu_op = base_op(f3);
               if (f7 == F7_ALT) begin
                  if (f3 == F3_ADD_SUB) alu_op = ALU_SUB;
                  else if (f3 == F3_SR) alu_op = ALU_SRA;
                  else illegal = 1'b1;
               end else if (f7 != F7_BASE) begin
                  illegal = 1'b1;
               end
            end
            default: illegal = 1'b1;
         endcase
      end
      if (illegal) begin
         alu_op = ALU_ADD;
         a_sel  = A_SEL_RS1;
         b_sel  = B_SEL_RS2;
         imm    = '0;
      end
   end

   assign rd_we = !illegal && (rd != 5'd0);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage: valid/ready handshake around a single registered decode bundle
// Flush beats capture; async reset discards any held bundle at once.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [31:0]            i_instr,
   input  logic [XLEN-1:0]        i_pc,
   input  logic                   i_flush,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [XLEN-1:0]        o_pc,
   output logic [ALUOP_WIDTH-1:0] o_alu_op,
   output logic [1:0]             o_a_sel,
   output logic                   o_b_sel,
   output logic [XLEN-1:0]        o_imm,
   output logic [4:0]             o_rs1,
   output logic [4:0]             o_rs2,
   output logic [4:0]             o_rd,
   output logic                   o_rd_we,
   output logic                   o_illegal
);

   logic [ALUOP_WIDTH-1:0] d_alu_op;
   logic [1:0]             d_a_sel;
   logic                   d_b_sel;
   logic [31:0]            d_imm;
   logic [4:0]             d_rs1;
   logic [4:0]             d_rs2;
   logic [4:0]             d_rd;
   logic                   d_rd_we;
   logic                   d_illegal;
   logic                   capture;

   instr_dec u_instr_dec (
      .instr   (i_instr),
      .alu_op  (d_alu_op),
      .a_sel   (d_a_sel),
      .b_sel   (d_b_sel),
      .imm     (d_imm),
      .rs1     (d_rs1),
      .rs2     (d_rs2),
      .rd      (d_rd),
      .rd_we   (d_rd_we),
      .illegal (d_illegal)
   );

   assign o_ready = !o_valid || i_ready;
   assign capture = i_valid && o_ready && !i_flush;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid   <= 1'b0;
         o_pc      <= RESET_PC;
         o_alu_op  <= ALU_ADD;
         o_a_sel   <= '0;
         o_b_sel   <= 1'b0;
         o_imm     <= '0;
         o_rs1     <= '0;
         o_rs2     <= '0;
         o_rd      <= '0;
         o_rd_we   <= 1'b0;
         o_illegal <= 1'b0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (capture) begin
         o_valid   <= 1'b1;
         o_pc      <= i_pc;
         o_alu_op  <= d_alu_op;
         o_a_sel   <= d_a_sel;
         o_b_sel   <= d_b_sel;
         o_imm     <= d_imm;
         o_rs1     <= d_rs1;
         o_rs2     <= d_rs2;
         o_rd      <= d_rd;
         o_rd_we   <= d_rd_we;
         o_illegal <= d_illegal;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with a mnemonic-level reference decoder
module tb_decode_stage;
   import decode_stage_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  op;
      logic [1:0]  a;
      logic        b;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst, vld, flush, rdy;
   logic [31:0] instr, pc;
   logic        o_ready, o_valid, o_b_sel, o_rd_we, o_illegal;
   logic [31:0] o_pc, o_imm;
   logic [3:0]  o_alu_op;
   logic [1:0]  o_a_sel;
   logic [4:0]  o_rs1, o_rs2, o_rd;

   int checks = 0, failures = 0;
   int pushed = 0, consumed = 0, dropped = 0;
   bit mon_en = 0;
   bit mv = 0;
   bit p_v = 0, p_r = 0, p_f = 0;
   logic [31:0] p_i = '0, p_pc = '0;
   bundle_t exp_q[$];

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(o_ready),
      .i_instr(instr), .i_pc(pc), .i_flush(flush), .o_valid(o_valid),
      .i_ready(rdy), .o_pc(o_pc), .o_alu_op(o_alu_op), .o_a_sel(o_a_sel),
      .o_b_sel(o_b_sel), .o_imm(o_imm), .o_rs1(o_rs1), .o_rs2(o_rs2),
      .o_rd(o_rd), .o_rd_we(o_rd_we), .o_illegal(o_illegal)
   );

   // Reference decoder written per mnemonic class
   function automatic bundle_t model(input logic [31:0] w, input logic [31:0] at);
      bundle_t r;
      logic [3:0] f3map [8];
      bit legal;
      logic [6:0] f7;
      logic [2:0] f3;
      f3map = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      r = '0;
      r.pc = at; r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
      f7 = w[31:25]; f3 = w[14:12];
      legal = 0;
      if (w[6:0] == 7'h37 || w[6:0] == 7'h17) begin
         legal = 1; r.op = ALU_ADD; r.b = 1;
         r.a = (w[6:0] == 7'h37) ? 2'd2 : 2'd1;
         r.imm = w & 32'hFFFF_F000;
      end else if (w[6:0] == 7'h13) begin
         r.b = 1; r.op = f3map[f3];
         r.imm = 32'($signed(w) >>> 20);
         if (f3 == 3'd1 || f3 == 3'd5) begin
            r.imm = 32'(w[24:20]);
            legal = (f7 == 7'd0) || (f3 == 3'd5 && f7 == 7'd32);
            if (f3 == 3'd5 && f7 == 7'd32) r.op = ALU_SRA;
         end else legal = 1;
      end else if (w[6:0] == 7'h33) begin
         legal = (f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5));
         r.op = f3map[f3];
         if (f7 == 7'd32 && f3 == 3'd0) r.op = ALU_SUB;
         if (f7 == 7'd32 && f3 == 3'd5) r.op = ALU_SRA;
      end
      if (!legal) begin
         r.op = ALU_ADD; r.a = 0; r.b = 0; r.imm = 0; r.ill = 1; r.we = 0;
      end else r.we = (r.rd != 0);
      return r;
   endfunction

   function automatic bundle_t dut_bundle();
      return '{o_pc, o_alu_op, o_a_sel, o_b_sel, o_imm, o_rs1, o_rs2, o_rd, o_rd_we, o_illegal};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Advance one clock: apply the handshake model for the edge just taken, then drive new inputs
   task automatic step(input bit v, input logic [31:0] w, input logic [31:0] at,
                       input bit r, input bit f);
      @(posedge clk);
      if (p_f) begin
         dropped += exp_q.size(); exp_q.delete(); mv = 0;
      end else if (p_v && (!mv || p_r)) begin
         exp_q.push_back(model(p_i, p_pc)); pushed++; mv = 1;
      end else if (p_r) mv = 0;
      #1;
      vld = v; instr = w; pc = at; rdy = r; flush = f;
      p_v = v; p_i = w; p_pc = at; p_r = r; p_f = f;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("o_ready", 128'(o_ready), 128'(!mv || rdy));
         chk("o_valid", 128'(o_valid), 128'(exp_q.size() != 0));
         if (o_valid && exp_q.size() != 0) begin
            chk("bundle", 128'(dut_bundle()), 128'(exp_q[0]));
            if (rdy && !flush) begin
               void'(exp_q.pop_front()); consumed++;
            end
         end
      end
   end

   task automatic directed(input string name, input logic [31:0] w, input logic [3:0] op,
                           input logic [31:0] imm, input bit ill, input bit we);
      step(1, w, 32'h2000, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      chk({name, "_op"}, 128'(o_alu_op), 128'(op));
      chk({name, "_imm"}, 128'(o_imm), 128'(imm));
      chk({name, "_ill"}, 128'(o_illegal), 128'(ill));
      chk({name, "_we"}, 128'(o_rd_we), 128'(we));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int k;
      w = $urandom();
      k = $urandom_range(0, 9);
      case (k)
         0, 1, 2: w[6:0] = 7'h33;
         3, 4, 5: w[6:0] = 7'h13;
         6: w[6:0] = 7'h37;
         7: w[6:0] = 7'h17;
         default: ;
      endcase
      k = $urandom_range(0, 3);
      if (k == 0) w[31:25] = 7'h00;
      else if (k == 1) w[31:25] = 7'h20;
      return w;
   endfunction

   initial begin
      rst = 1; vld = 0; flush = 0; rdy = 0; instr = 0; pc = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 128'(o_valid), 128'(0));
      chk("rst_ready", 128'(o_ready), 128'(1));
      chk("rst_pc", 128'(o_pc), 128'(RST_PC));
      chk("rst_rest", 128'({o_alu_op, o_a_sel, o_b_sel, o_imm, o_rs1, o_rs2, o_rd, o_rd_we, o_illegal}), 128'(0));
      rst = 0; mon_en = 1;

      directed("addi", 32'h00500093, ALU_ADD, 32'd5, 0, 1);
      chk("addi_sel", 128'({o_a_sel, o_b_sel, o_rd}), 128'({2'd0, 1'b1, 5'd1}));
      directed("sub", 32'h402081B3, ALU_SUB, 32'd0, 0, 1);
      chk("sub_regs", 128'({o_rs1, o_rs2, o_rd, o_b_sel}), 128'({5'd1, 5'd2, 5'd3, 1'b0}));
      directed("srai", 32'h40335293, ALU_SRA, 32'd3, 0, 1);
      directed("lui", 32'h123453B7, ALU_ADD, 32'h12345000, 0, 1);
      chk("lui_a", 128'(o_a_sel), 128'(2'd2));
      directed("sltiu", 32'hFFF03213, ALU_SLTU, 32'hFFFFFFFF, 0, 1);
      directed("ones", 32'hFFFFFFFF, ALU_ADD, 32'd0, 1, 0);
      directed("add_x0", 32'h00208033, ALU_ADD, 32'd0, 0, 0);

      // stall with a waiting instruction, then release back-to-back
      step(1, 32'h00500093, 32'h3000, 1, 0);
      repeat (3) step(1, 32'h402081B3, 32'h3004, 0, 0);
      step(1, 32'h402081B3, 32'h3004, 1, 0);
      step(1, 32'h40335293, 32'h3008, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      // flush with a held bundle and a same-cycle capture
      step(1, 32'h00500093, 32'h4000, 0, 0);
      step(1, 32'h123453B7, 32'h4004, 1, 1);
      step(0, 32'h0, 32'h0, 1, 0);
      chk("flush_valid", 128'(o_valid), 128'(0));

      // reset asserted while a bundle is stalled
      step(1, 32'h123453B7, 32'h5000, 1, 0);
      step(0, 32'h0, 32'h0, 0, 0);
      step(0, 32'h0, 32'h0, 0, 0);
      chk("stall_held", 128'({o_valid, o_pc}), 128'({1'b1, 32'h5000}));
      mon_en = 0;
      rst = 1;
      #1;
      chk("midrst_valid", 128'(o_valid), 128'(0));
      chk("midrst_pc", 128'(o_pc), 128'(RST_PC));
      chk("midrst_rest", 128'({o_alu_op, o_a_sel, o_b_sel, o_imm, o_rs1, o_rs2, o_rd, o_rd_we, o_illegal}), 128'(0));
      dropped += exp_q.size(); exp_q.delete(); mv = 0;
      p_v = 0; p_r = 0; p_f = 0;
      @(posedge clk);
      #1;
      rst = 0; mon_en = 1;

      for (int n = 0; n < 1500; n++)
         step($urandom_range(0, 9) < 7, rand_instr(), $urandom(),
              $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      for (int n = 0; n < 4; n++) step(0, 32'h0, 32'h0, 1, 0);

      chk("drain_empty", 128'(exp_q.size()), 128'(0));
      chk("conservation", 128'(consumed + dropped), 128'(pushed));
      mon_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
